// File: rtl/spi_pkg.sv
// Shared definitions for the byte-wide mode-0 SPI controller.
package spi_pkg;

    localparam int unsigned SPI_BITS   = 8;
    localparam int unsigned HALF_COUNT = 2 * SPI_BITS;
    localparam int unsigned HALF_CNT_W = $clog2(HALF_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } state_t;

endpackage

// File: rtl/spi_if.sv
// Handshake and serial-link signals of the SPI controller.
interface spi_if;
    import spi_pkg::*;

    logic                start;
    logic [SPI_BITS-1:0] tx_data;
    logic [SPI_BITS-1:0] rx_data;
    logic                busy;
    logic                done;
    logic                sclk;
    logic                cs_n;
    logic                mosi;
    logic                miso;

    modport master (
        input  start,
        input  tx_data,
        input  miso,
        output rx_data,
        output busy,
        output done,
        output sclk,
        output cs_n,
        output mosi
    );

    modport slave (
        output start,
        output tx_data,
        output miso,
        input  rx_data,
        input  busy,
        input  done,
        input  sclk,
        input  cs_n,
        input  mosi
    );

endinterface

// File: rtl/spi_clkgen.sv
// Half-period timer: one-cycle tick every CLK_DIV enabled cycles.
module spi_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/spi_controller.sv
// Mode-0 MSB-first SPI initiator, one 8-bit full-duplex transfer per start.
// Optional SPI_MISO_SYNC_EN adds a two-flop miso synchronizer (CLK_DIV >= 3).
module spi_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    spi_if.master bus
);
    import spi_pkg::*;

    localparam logic [HALF_CNT_W-1:0] LAST_HALF = HALF_CNT_W'(HALF_COUNT - 1);
    localparam logic [HALF_CNT_W-1:0] LAST_HIGH = HALF_CNT_W'(HALF_COUNT - 2);

    state_t                state, state_d;
    logic [HALF_CNT_W-1:0] half, half_d;
    logic [SPI_BITS-1:0]   tx_sh, tx_d;
    logic [SPI_BITS-1:0]   rx_sh, rx_d;
    logic [SPI_BITS-1:0]   rx_out, rx_out_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  clk_en, clk_clr, tick;
    logic                  miso_s;

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] miso_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_sync <= '0;
        end else begin
            miso_sync <= {miso_sync[0], bus.miso};
        end
    end

    assign miso_s = miso_sync[1];
`else
    assign miso_s = bus.miso;
`endif

    spi_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (clk_en),
        .clr  (clk_clr),
        .tick (tick)
    );

    // mosi is the MSB of the transmit register, so it is registered by
    // construction; clearing the register on exit returns mosi to 0.
    assign bus.mosi    = tx_sh[SPI_BITS-1];
    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_out;

    always_comb begin
        state_d  = state;
        half_d   = half;
        tx_d     = tx_sh;
        rx_d     = rx_sh;
        rx_out_d = rx_out;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        clk_en   = (state != IDLE);
        clk_clr  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = LEAD;
                    tx_d    = bus.tx_data;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    half_d  = '0;
                    clk_clr = 1'b1;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = XFER;
                    sclk_d  = 1'b1;
                end
            end
            XFER: begin
                if (tick) begin
                    half_d = half + HALF_CNT_W'(1);
                    if (!half[0]) begin
                        // end of a high phase: sample miso, then fall
                        rx_d   = {rx_sh[SPI_BITS-2:0], miso_s};
                        sclk_d = 1'b0;
                        if (half != LAST_HIGH) begin
                            tx_d = {tx_sh[SPI_BITS-2:0], 1'b0};
                        end
                    end else if (half == LAST_HALF) begin
                        state_d = TRAIL;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_d  = IDLE;
                    cs_n_d   = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    tx_d     = '0;
                    rx_out_d = rx_sh;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            half   <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            rx_out <= '0;
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            half   <= half_d;
            tx_sh  <= tx_d;
            rx_sh  <= rx_d;
            rx_out <= rx_out_d;
            sclk_q <= sclk_d;
            cs_n_q <= cs_n_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: loopback and peripheral-model transfers.
// Uses CLK_DIV=3 when SPI_MISO_SYNC_EN is defined, otherwise CLK_DIV=2.
module tb_spi_controller;

`ifdef SPI_MISO_SYNC_EN
    localparam int unsigned D = 3;
`else
    localparam int unsigned D = 2;
`endif
    localparam int unsigned LIMIT = 60 * D;

    typedef struct {
        logic [7:0]  rx;
        logic [7:0]  tx;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic lb;
    logic p_bit;
    logic [7:0] periph_byte;

    spi_if bus ();

    assign bus.miso = lb ? bus.mosi : p_bit;

    spi_controller #(
        .CLK_DIV(D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned rises = 0;
    int unsigned lowcnt = 0;
    int unsigned hi_run = 0;
    logic        b2b_chk = 1'b0;
    logic [7:0]  mosi_bits = '0;
    logic [7:0]  p_sh = '0;
    exp_t        exp_q[$];

    task automatic chk(input string nm, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout after %0d cycles expected completion", nm, LIMIT);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Peripheral model, acceptance observer and scoreboard monitor.
    initial begin : monitor
        logic cs_prev, sclk_prev;
        exp_t e;
        cs_prev = 1'b1;
        sclk_prev = 1'b0;
        p_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cs_prev = 1'b1;
                sclk_prev = 1'b0;
                hi_run = 0;
            end else begin
                if (cs_prev && !bus.cs_n) begin
                    if (b2b_chk) begin
                        chk("b2b_gap", hi_run, 1);
                        b2b_chk = 1'b0;
                    end
                    lowcnt = 0;
                    rises = 0;
                    mosi_bits = '0;
                    p_sh = periph_byte;
                end
                if (!bus.cs_n) begin
                    lowcnt++;
                    hi_run = 0;
                end else begin
                    hi_run++;
                end
                if (bus.sclk && !sclk_prev) begin
                    rises++;
                    mosi_bits = {mosi_bits[6:0], bus.mosi};
                end
                if (!bus.sclk && sclk_prev && !bus.cs_n) p_sh = {p_sh[6:0], 1'b0};
                p_bit = p_sh[7];

                if (bus.start && !bus.busy) begin
                    e.tx  = bus.tx_data;
                    e.rx  = lb ? bus.tx_data : periph_byte;
                    e.cyc = cyc + 1 + 18 * D;
                    exp_q.push_back(e);
                    acc_cnt++;
                end

                if (bus.done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", bus.rx_data, e.rx);
                        chk("done_cycle", cyc, e.cyc);
                        chk("mosi_bits", mosi_bits, e.tx);
                        chk("sclk_rises", rises, 8);
                        chk("cs_low_cycles", lowcnt, 18 * D);
                        chk("busy_at_done", bus.busy, 0);
                        chk("mosi_at_done", bus.mosi, 0);
                    end
                end
                cs_prev = bus.cs_n;
                sclk_prev = bus.sclk;
            end
        end
    end

    task automatic do_xfer(input logic lbm, input logic [7:0] tx, input logic [7:0] pb);
        int unsigned n;
        n = 0;
        @(posedge clk); #1;
        while (bus.busy && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= LIMIT) timeout("wait_ready");
        lb = lbm;
        periph_byte = pb;
        bus.tx_data = tx;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.tx_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= LIMIT) timeout("wait_idle");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int unsigned d0, b0, n;
        rst_n = 1'b1;
        lb = 1'b1;
        periph_byte = '0;
        bus.start = 1'b0;
        bus.tx_data = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        rst_n = 1'b1;

        do_xfer(1'b1, 8'hA5, 8'h00);
        wait_idle();
        do_xfer(1'b0, 8'h00, 8'hFF);
        wait_idle();
        do_xfer(1'b0, 8'h5A, 8'hC3);
        wait_idle();

        // start pulse mid-transfer must be ignored
        d0 = done_cnt;
        do_xfer(1'b1, 8'h69, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.tx_data = 8'h3C;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        chk("ignored_start_dones", done_cnt - d0, 1);

        // start held high: two back-to-back transfers
        d0 = done_cnt;
        b0 = acc_cnt;
        lb = 1'b1;
        bus.tx_data = 8'h81;
        bus.start = 1'b1;
        n = 0;
        while (acc_cnt < b0 + 1 && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= LIMIT) timeout("b2b_first");
        bus.tx_data = 8'h7E;
        @(negedge clk); #1;
        b2b_chk = 1'b1;
        n = 0;
        while (acc_cnt < b0 + 2 && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= LIMIT) timeout("b2b_second");
        bus.start = 1'b0;
        wait_idle();
        chk("b2b_dones", done_cnt - d0, 2);
        chk("b2b_gap_seen", b2b_chk, 0);

        // reset after the 4th sclk rise
        do_xfer(1'b1, 8'hE7, 8'h00);
        repeat (2) @(posedge clk);
        n = 0;
        while (rises < 4 && n < LIMIT) begin
            @(posedge clk);
            n++;
        end
        if (n >= LIMIT) timeout("wait_4th_rise");
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", bus.cs_n, 1);
        chk("abort_sclk", bus.sclk, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_rx_data", bus.rx_data, 0);
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20 * D) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_rx_kept", bus.rx_data, 0);
        do_xfer(1'b1, 8'h96, 8'h00);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            do_xfer(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_controller.md
# spi_controller

Byte-wide SPI controller (initiator) for mode 0 (CPOL=0, CPHA=0), MSB first. It is the initiating end of the link our shift-register peripheral implements. It generates `sclk`, `cs_n` and `mosi` from the system clock and captures `miso` into `rx_data`. A start/busy/done handshake lets a local FSM or test harness launch one 8-bit full-duplex transfer at a time.

## Interface
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles; legal range ≥2, or ≥3 when `SPI_MISO_SYNC_EN` is defined.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: launches a transfer when sampled high while `busy`=0.
- `tx_data` input 8: byte to send; latched in the cycle `start` is accepted.
- `rx_data` output 8: last received byte; valid from the `done` cycle until the next `done`.
- `busy` output 1: transfer in progress.
- `done` output 1: one-cycle pulse at the end of a transfer.
- `sclk` output 1: SPI clock; idles low.
- `cs_n` output 1: chip select, active-low.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.

## Operation
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=8'h00. All state returns to IDLE immediately on reset, including mid-transfer.
- FSM states and transitions:
  - IDLE → LEAD on an accepted `start`.
  - LEAD: CLK_DIV cycles, `cs_n`=0, `sclk`=0, `mosi`=`tx_data[7]`.
  - LEAD → XFER: 16 half-periods of CLK_DIV cycles each. `sclk` rises at the start of each odd half-period and falls at the start of each even one.
  - XFER → TRAIL: CLK_DIV cycles, `sclk`=0, `cs_n`=0.
  - TRAIL → IDLE.
- Shifting:
  - `miso` is sampled in the last `clk` cycle of each `sclk` high phase and shifted into the receive register LSB-side.
  - `mosi` advances to the next bit at each falling edge.
  - After the 8th falling edge, `mosi` holds bit 0 until TRAIL ends, then returns to 0.
- Handshake:
  - `start` is ignored while `busy`=1.
  - `start` is accepted in the same cycle `done` is high, because the FSM is already in IDLE. This gives back-to-back transfers with one `cs_n`-high cycle between them.
- `tx_data` changes after acceptance have no effect on the transfer in progress.
- `rx_data` updates only in the `done` cycle. A transfer aborted by reset leaves `rx_data`=0.

## Timing
- Start accepted in cycle 0:
  - `busy` and `cs_n`=0 from cycle 1.
  - First `sclk` rise at cycle 1+CLK_DIV.
  - `cs_n` low for exactly 18·CLK_DIV cycles.
  - In cycle 1+18·CLK_DIV: `cs_n`=1, `busy`=0, `done`=1, `rx_data` valid.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `sclk` period is 2·CLK_DIV with 50% duty; exactly 8 rising edges per transfer.

## Configuration
- `SPI_MISO_SYNC_EN` defined:
  - `miso` passes through a two-flop synchronizer before sampling.
  - The sampled bit reflects `miso` as it was 2 cycles before the sample point.
  - Requires CLK_DIV ≥3.
- `SPI_MISO_SYNC_EN` undefined: `miso` is sampled directly, and is assumed synchronous to `clk` (simulation and on-chip loopback).
- Handshake, `sclk`/`cs_n`/`mosi` timing and latency are identical in both builds.

## Structure
- Shared package `spi_pkg`:
  - FSM state encoding (IDLE, LEAD, XFER, TRAIL).
  - `SPI_BITS`=8.
  - Half-period count width.
- Sub-module `spi_clkgen`: CLK_DIV counter producing a one-cycle half-period tick, with enable/clear controlled by the FSM.
- Shift registers and the FSM live in `spi_controller`.

## Test plan
- Loopback (`miso`=`mosi`), CLK_DIV=2, `tx_data`=8'hA5:
  - `mosi` bits sampled at `sclk` rises are 1,0,1,0,0,1,0,1.
  - `rx_data`=8'hA5 and `done` in cycle 37.
  - `cs_n` low 36 cycles.
- `miso` tied 1, `tx_data`=8'h00 → `rx_data`=8'hFF, `mosi` constant 0, exactly 8 `sclk` rises.
- `start` pulsed again 5 cycles into a transfer with `tx_data`=8'h3C → ignored. The original byte completes and exactly one `done` pulse is seen.
- `start` held high continuously, `tx_data`=8'h81 then 8'h7E at acceptance → two transfers, exactly one `cs_n`-high cycle between them, one `done` per transfer.
- `rst_n` asserted mid-XFER (after the 4th `sclk` rise) → same cycle: `cs_n`=1, `sclk`=0, `busy`=0. `rx_data`=0, no `done`. A new start after release works normally.
- `SPI_MISO_SYNC_EN` build, CLK_DIV=3, `miso` driven by a mode-0 peripheral model returning 8'hC3 → `rx_data`=8'hC3; timing is identical to the unsynchronized build.
